// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data-memory port. Takes one byte/half/word load or
//   store from the integer datapath and drives a big-endian, word-wide data
//   memory (combinational read, posedge write). Sub-word stores are done as
//   a read-modify-write of the aligned word.
//
// Ports
//   clk, reset           clock (posedge) and asynchronous active-high reset
//   ls_req/we/size/signed/addr/wdata
//                        request from the datapath, sampled only when idle
//   ls_busy              high whenever a request is in flight
//   ls_done, ls_err      registered one-cycle completion pulse and error flag
//   ls_rdata             last successful load result (zero/sign extended)
//   dm_cs/rd/wr          memory chip select, read and write enables
//   dm_addr              word-aligned memory address
//   dm_wdata, dm_rdata   memory write and read data
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_busy,
  output logic        ls_done,
  output logic        ls_err,
  output logic [31:0] ls_rdata,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] LastWordAddr = 32'(MEM_BYTES - 4);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeBad  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLdRd,
    StStWr,
    StRmwRd,
    StRmwWr
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_err;
  logic        accept;
  logic        load_cpl;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] merged;

  // Request legality is judged on the live inputs in the accepting cycle.
  always_comb begin
    req_err = 1'b0;
    if (ls_size == SizeBad) req_err = 1'b1;
    if (ls_size == SizeHalf && ls_addr[0]) req_err = 1'b1;
    if (ls_size == SizeWord && ls_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({ls_addr[31:2], 2'b00} > LastWordAddr) req_err = 1'b1;
  end

  assign accept = (state_q == StIdle) && ls_req;

  // Big-endian lane extraction: byte offset 0 is the most significant byte.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = dm_rdata[31:24];
      2'd1:    ld_byte = dm_rdata[23:16];
      2'd2:    ld_byte = dm_rdata[15:8];
      default: ld_byte = dm_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    case (size_q)
      SizeByte: ld_value = {{24{signed_q & ld_byte[7]}}, ld_byte};
      SizeHalf: ld_value = {{16{signed_q & ld_half[15]}}, ld_half};
      default:  ld_value = dm_rdata;
    endcase
  end

  // Old word with the target lane replaced by the store data.
  always_comb begin
    merged = merge_q;
    if (size_q == SizeByte) begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  // Memory strobes decode straight from the state register so that an
  // asynchronous reset removes them at once.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load_cpl = 1'b0;
    dm_cs    = 1'b0;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_wdata = 32'h0;
    case (state_q)
      StIdle: begin
        if (ls_req) begin
          if (req_err) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (!ls_we) begin
            state_d = StLdRd;
          end else if (ls_size == SizeWord) begin
            state_d = StStWr;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLdRd: begin
        dm_cs    = 1'b1;
        dm_rd    = 1'b1;
        load_cpl = 1'b1;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      StStWr: begin
        dm_cs    = 1'b1;
        dm_wr    = 1'b1;
        dm_wdata = wdata_q;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      StRmwRd: begin
        dm_cs   = 1'b1;
        dm_rd   = 1'b1;
        state_d = StRmwWr;
      end
      StRmwWr: begin
        dm_cs    = 1'b1;
        dm_wr    = 1'b1;
        dm_wdata = merged;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q   <= ls_addr;
        size_q   <= ls_size;
        signed_q <= ls_signed;
        wdata_q  <= ls_wdata;
      end
      if (state_q == StRmwRd) merge_q <= dm_rdata;
      if (load_cpl) rdata_q <= ld_value;
    end
  end

  assign ls_busy  = (state_q != StIdle);
  assign ls_done  = done_q;
  assign ls_err   = err_q;
  assign ls_rdata = rdata_q;
  assign dm_addr  = {addr_q[31:2], 2'b00};

endmodule
